multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the core datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_ctrl_if.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
//   Bundle between the multi-cycle sequencer and the datapath / shared
//   instruction-data memory port.
//
//   Handshake: the controller holds mem_req (and mem_we / mem_half) steady
//   until the memory answers with mem_ready in the same cycle. A cycle with
//   mem_req=1 and mem_ready=1 completes the request. mem_ready while
//   mem_req=0 has no meaning and is ignored.
//
//   master : controller side (drives strobes, state, fault, retired)
//   slave  : datapath / memory side (drives instr, zero, mem_ready)
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if #(
   parameter int RET_W = 16
) ();
   // datapath / memory -> controller
   logic [31:0]      instr;
   logic             zero;
   logic             mem_ready;
   // controller -> datapath / memory
   logic [2:0]       state;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       pc_src;
   logic             mem_req;
   logic             mem_we;
   logic             mem_half;
   logic             reg_write;
   logic [1:0]       wb_sel;
   logic             alu_src;
   logic [3:0]       alu_control;
   logic             fault;
   logic [RET_W-1:0] retired;

   modport master (
      input  instr, zero, mem_ready,
      output state, ir_write, pc_write, pc_src, mem_req, mem_we, mem_half,
             reg_write, wb_sel, alu_src, alu_control, fault, retired
   );

   modport slave (
      output instr, zero, mem_ready,
      input  state, ir_write, pc_write, pc_src, mem_req, mem_we, mem_half,
             reg_write, wb_sel, alu_src, alu_control, fault, retired
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//   Multi-cycle sequencer: steps each instruction through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB), driving datapath strobes and
//   ALU selects, with a memory-wait timeout that drops into a sticky FAULT
//   state and a wrapping retired-instruction counter.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset; all strobes forced low while high
//   bus    : multicycle_ctrl_if.master (instr/zero/mem_ready in, strobes,
//            state, fault, retired out)
//
// Parameters
//   MEM_TIMEOUT : max wait cycles with mem_req high and no mem_ready (>=1)
//   RET_W       : width of the retired-instruction counter
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int RET_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   multicycle_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd7
   } state_e;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LH  = 7'b0001011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_SH  = 7'b0101011;
   localparam logic [6:0] OP_BNE = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLL = 4'b0101;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [6:0]         opcode_q, opcode_d;
   logic [2:0]         funct3_q, funct3_d;
   logic [6:0]         funct7_q, funct7_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [RET_W-1:0]   retired_q, retired_d;

   // Register/immediate fields never influence sequencing.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

   function automatic logic is_legal(input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      case (w[6:0])
         OP_R: begin
            case (w[14:12])
               3'b000:         ok = (w[31:25] == F7_ADD) || (w[31:25] == F7_SUB);
               3'b110, 3'b001: ok = 1'b1;
               default:        ok = 1'b0;
            endcase
         end
         OP_I:                        ok = (w[14:12] == 3'b000) || (w[14:12] == 3'b111);
         OP_LH, OP_SW, OP_SH, OP_JAL: ok = 1'b1;
         OP_BNE:                      ok = (w[14:12] == 3'b001);
         default:                     ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Instruction class from the fields latched in DECODE.
   logic is_r, is_i, is_lh, is_sw, is_sh, is_bne, is_jal, is_store, is_mem;
   assign is_r     = (opcode_q == OP_R);
   assign is_i     = (opcode_q == OP_I);
   assign is_lh    = (opcode_q == OP_LH);
   assign is_sw    = (opcode_q == OP_SW);
   assign is_sh    = (opcode_q == OP_SH);
   assign is_bne   = (opcode_q == OP_BNE);
   assign is_jal   = (opcode_q == OP_JAL);
   assign is_store = is_sw || is_sh;
   assign is_mem   = is_lh || is_store;

   // ALU selects; held unchanged from EXEC through MEM/WB.
   logic       alu_src_k;
   logic [3:0] alu_ctl_k;
   always_comb begin
      alu_src_k = is_i || is_mem;
      alu_ctl_k = ALU_ADD;
      if (is_r) begin
         case (funct3_q)
            3'b000:  alu_ctl_k = (funct7_q == F7_SUB) ? ALU_SUB : ALU_ADD;
            3'b110:  alu_ctl_k = ALU_OR;
            3'b001:  alu_ctl_k = ALU_SLL;
            default: alu_ctl_k = ALU_ADD;
         endcase
      end else if (is_i && (funct3_q == 3'b111)) begin
         alu_ctl_k = ALU_AND;
      end else if (is_bne) begin
         alu_ctl_k = ALU_SUB;
      end
   end

   // Next-state, field latch, wait counter and retire counter.
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      funct7_d  = funct7_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready)           state_d = S_DECODE;
            else if (wait_q == WAIT_LAST) state_d = S_FAULT;
            else                         wait_d  = wait_q + WAIT_W'(1);
         end
         S_DECODE: begin
            opcode_d = bus.instr[6:0];
            funct3_d = bus.instr[14:12];
            funct7_d = bus.instr[31:25];
            state_d  = is_legal(bus.instr) ? S_EXEC : S_FAULT;
         end
         S_EXEC: begin
            if (is_bne || is_jal) begin
               retired_d = retired_q + RET_W'(1);
               state_d   = S_FETCH;
            end else if (is_mem) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (bus.mem_ready) begin
               if (is_lh) begin
                  state_d = S_WB;
               end else begin
                  retired_d = retired_q + RET_W'(1);
                  state_d   = S_FETCH;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            retired_d = retired_q + RET_W'(1);
            state_d   = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase
      // Every fresh memory request starts its wait budget from zero.
      if (((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q)) begin
         wait_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         opcode_q  <= '0;
         funct3_q  <= '0;
         funct7_q  <= '0;
         wait_q    <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         funct3_q  <= funct3_d;
         funct7_q  <= funct7_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
      end
   end

   // Strobes decode from state and latched fields; reset masks them all.
   always_comb begin
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.pc_src      = 2'd0;
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_half    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.wb_sel      = 2'd0;
      bus.alu_src     = 1'b0;
      bus.alu_control = ALU_ADD;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               bus.mem_req  = 1'b1;
               bus.ir_write = bus.mem_ready;
            end
            S_EXEC: begin
               bus.alu_src     = alu_src_k;
               bus.alu_control = alu_ctl_k;
               if (is_bne) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = bus.zero ? 2'd0 : 2'd1;
               end else if (is_jal) begin
                  bus.pc_write  = 1'b1;
                  bus.pc_src    = 2'd2;
                  bus.reg_write = 1'b1;
                  bus.wb_sel    = 2'd2;
               end
            end
            S_MEM: begin
               bus.mem_req     = 1'b1;
               bus.mem_we      = is_store;
               bus.mem_half    = is_lh || is_sh;
               bus.alu_src     = alu_src_k;
               bus.alu_control = alu_ctl_k;
               bus.pc_write    = bus.mem_ready && is_store;
            end
            S_WB: begin
               bus.reg_write   = 1'b1;
               bus.wb_sel      = is_lh ? 2'd1 : 2'd0;
               bus.pc_write    = 1'b1;
               bus.alu_src     = alu_src_k;
               bus.alu_control = alu_ctl_k;
            end
            default: ;
         endcase
      end
   end

   assign bus.state   = state_q;
   assign bus.fault   = (state_q == S_FAULT);
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;
   localparam int T  = 15;
   localparam int RW = 4;           // narrow counter so wrap-around is reached
   localparam int W  = 19 + RW;

   localparam int K_ADD = 0, K_SUB = 1, K_OR = 2, K_SLL = 3, K_ADDI = 4, K_ANDI = 5;
   localparam int K_LH = 6, K_SW = 7, K_SH = 8, K_BNE = 9, K_JAL = 10, K_ILL = 11;

   typedef struct {
      logic [2:0] st;
      logic       irw, pcw;
      logic [1:0] pcs;
      logic       mreq, mwe, mhalf, rw;
      logic [1:0] wbs;
      logic       asrc;
      logic [3:0] actl;
      logic       sc, cc;   // alu_src / alu_control defined this cycle
      logic       rst;      // reset cycle: only strobes are defined
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   multicycle_ctrl_if #(.RET_W(RW)) bus ();
   multicycle_ctrl #(.MEM_TIMEOUT(T), .RET_W(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] msk_q[$];
   string        tag_q[$];
   int checks = 0;
   int errors = 0;
   int ret    = 0;   // reference retired count

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic exp_t ex(input logic [2:0] st);
      exp_t e;
      e = '{default: '0};
      e.st = st;
      return e;
   endfunction

   function automatic logic [3:0] alu_of(input int k);
      case (k)
         K_SUB, K_BNE: return 4'b0001;
         K_OR:         return 4'b0011;
         K_SLL:        return 4'b0101;
         K_ANDI:       return 4'b0010;
         default:      return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] enc(input int k);
      logic [31:0] w;
      int v;
      w = $urandom();
      case (k)
         K_ADD:  begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0000000; end
         K_SUB:  begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = 7'b0100000; end
         K_OR:   begin w[6:0] = 7'b0110011; w[14:12] = 3'b110; end
         K_SLL:  begin w[6:0] = 7'b0110011; w[14:12] = 3'b001; end
         K_ADDI: begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
         K_ANDI: begin w[6:0] = 7'b0010011; w[14:12] = 3'b111; end
         K_LH:   w[6:0] = 7'b0001011;
         K_SW:   w[6:0] = 7'b0100011;
         K_SH:   w[6:0] = 7'b0101011;
         K_BNE:  begin w[6:0] = 7'b1100011; w[14:12] = 3'b001; end
         K_JAL:  w[6:0] = 7'b1101111;
         default: begin
            v = $urandom_range(0, 4);
            case (v)
               0: begin
                  do w[6:0] = 7'($urandom());
                  while (w[6:0] inside {7'b0110011, 7'b0010011, 7'b0001011, 7'b0100011,
                                        7'b0101011, 7'b1100011, 7'b1101111});
               end
               1: begin
                  w[6:0] = 7'b0110011;
                  v = $urandom_range(0, 4);
                  w[14:12] = (v == 4) ? 3'd7 : 3'(v + 2);
               end
               2: begin
                  w[6:0] = 7'b0110011; w[14:12] = 3'b000;
                  if (w[31:25] == 7'b0000000 || w[31:25] == 7'b0100000) w[31:25] = 7'b0000001;
               end
               3: begin w[6:0] = 7'b0010011; w[14:12] = 3'($urandom_range(1, 6)); end
               default: begin
                  w[6:0] = 7'b1100011;
                  v = $urandom_range(0, 6);
                  w[14:12] = (v >= 1) ? 3'(v + 1) : 3'd0;
               end
            endcase
         end
      endcase
      return w;
   endfunction

   // ---------------- driver ----------------
   task automatic step(input logic [31:0] ins, input logic rdy, input logic z,
                       input logic rst, input exp_t e, input string tag);
      logic [W-1:0] v, m;
      logic d;
      @(posedge clk);
      #1;
      reset         = rst;
      bus.instr     = ins;
      bus.mem_ready = rdy;
      bus.zero      = z;
      d = !e.rst;
      v = {e.st, e.irw, e.pcw, e.pcs, e.mreq, e.mwe, e.mhalf, e.rw, e.wbs,
           e.asrc, e.actl, (e.st == 3'd7), RW'(ret)};
      m = {{3{d}}, 1'b1, 1'b1, {2{e.pcw}}, 1'b1, 1'b1, 1'b1, 1'b1, {2{e.rw}},
           e.sc & d, {4{e.cc & d}}, d, {RW{d}}};
      exp_q.push_back(v);
      msk_q.push_back(m);
      tag_q.push_back(tag);
   endtask

   task automatic retire();
      ret = (ret + 1) % (1 << RW);
   endtask

   task automatic do_reset();
      exp_t e;
      e = ex(3'd0);
      e.rst = 1'b1;
      step($urandom(), rb(), rb(), 1'b1, e, "reset");
      ret = 0;
   endtask

   task automatic fault_tail();
      repeat (4) step($urandom(), rb(), rb(), 1'b0, ex(3'd7), "fault_hold");
      do_reset();
   endtask

   // One instruction: fw/mw = memory wait cycles in FETCH/MEM, zb = zero flag
   // in EXEC, rst_mem = assert reset after the MEM waits instead of completing.
   task automatic do_instr(input int k, input logic [31:0] ins, input int fw,
                           input int mw, input logic zb, input bit rst_mem);
      exp_t e;
      bit   is_mem, is_st;
      is_mem = (k == K_LH) || (k == K_SW) || (k == K_SH);
      is_st  = (k == K_SW) || (k == K_SH);
      for (int i = 0; i < ((fw < T) ? fw : T); i++) begin
         e = ex(3'd0); e.mreq = 1'b1;
         step(ins, 1'b0, rb(), 1'b0, e, "fetch_wait");
      end
      if (fw >= T) begin fault_tail(); return; end
      e = ex(3'd0); e.mreq = 1'b1; e.irw = 1'b1;
      step(ins, 1'b1, rb(), 1'b0, e, "fetch_done");
      step(ins, rb(), rb(), 1'b0, ex(3'd1), "decode");
      if (k == K_ILL) begin fault_tail(); return; end
      e = ex(3'd2);
      if (k == K_BNE) begin
         e.actl = 4'b0001; e.cc = 1'b1; e.pcw = 1'b1; e.pcs = zb ? 2'd0 : 2'd1;
         step($urandom(), rb(), zb, 1'b0, e, "exec_bne");
         retire();
         return;
      end
      if (k == K_JAL) begin
         e.pcw = 1'b1; e.pcs = 2'd2; e.rw = 1'b1; e.wbs = 2'd2;
         step($urandom(), rb(), rb(), 1'b0, e, "exec_jal");
         retire();
         return;
      end
      e.asrc = (k >= K_ADDI); e.actl = alu_of(k); e.sc = 1'b1; e.cc = 1'b1;
      step($urandom(), rb(), rb(), 1'b0, e, "exec");
      if (is_mem) begin
         e = ex(3'd3); e.mreq = 1'b1; e.mwe = is_st; e.mhalf = (k != K_SW);
         e.asrc = 1'b1; e.actl = 4'b0000; e.sc = 1'b1; e.cc = 1'b1;
         for (int i = 0; i < ((mw < T) ? mw : T); i++)
            step($urandom(), 1'b0, rb(), 1'b0, e, "mem_wait");
         if (rst_mem) begin do_reset(); return; end
         if (mw >= T) begin fault_tail(); return; end
         if (is_st) begin e.pcw = 1'b1; e.pcs = 2'd0; end
         step($urandom(), 1'b1, rb(), 1'b0, e, "mem_done");
         if (is_st) begin retire(); return; end
      end
      e = ex(3'd4); e.rw = 1'b1; e.wbs = (k == K_LH) ? 2'd1 : 2'd0;
      e.pcw = 1'b1; e.pcs = 2'd0;
      step($urandom(), rb(), rb(), 1'b0, e, "wb");
      retire();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] got, e, m;
      string t;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         m = msk_q.pop_front();
         t = tag_q.pop_front();
         got = {bus.state, bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_req, bus.mem_we,
                bus.mem_half, bus.reg_write, bus.wb_sel, bus.alu_src, bus.alu_control,
                bus.fault, bus.retired};
         checks++;
         if ((got & m) !== (e & m)) begin
            errors++;
            $display("FAIL %s @%0t: got %h required %h (care mask %h)", t, $time, got, e, m);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r, k, fw, mw;
      bus.instr = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      do_reset();
      do_reset();
      do_instr(K_ADD, 32'h002081B3, 0, 0, 1'b0, 1'b0);
      do_instr(K_LH, enc(K_LH), 0, 3, 1'b0, 1'b0);
      do_instr(K_BNE, enc(K_BNE), 0, 0, 1'b0, 1'b0);
      do_instr(K_BNE, enc(K_BNE), 0, 0, 1'b1, 1'b0);
      do_instr(K_JAL, enc(K_JAL), 1, 0, 1'b0, 1'b0);
      do_instr(K_ADD, enc(K_ADD), T, 0, 1'b0, 1'b0);       // fetch timeout
      do_instr(K_ADDI, enc(K_ADDI), T - 1, 0, 1'b0, 1'b0); // ready on last cycle
      do_instr(K_SUB, enc(K_SUB), 0, 0, 1'b0, 1'b0);
      do_instr(K_ILL, 32'h0000007F, 0, 0, 1'b0, 1'b0);
      do_instr(K_SW, enc(K_SW), 0, 2, 1'b0, 1'b1);         // reset during MEM
      do_instr(K_SH, enc(K_SH), 1, T, 1'b0, 1'b0);         // MEM timeout
      do_instr(K_SH, enc(K_SH), 0, T - 1, 1'b0, 1'b0);
      for (int n = 0; n < 400; n++) begin
         r  = $urandom_range(0, 99);
         k  = (r < 4) ? K_ILL : $urandom_range(0, 10);
         fw = ($urandom_range(0, 99) < 4) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
         mw = ($urandom_range(0, 99) < 4) ? $urandom_range(T - 1, T + 1) : $urandom_range(0, 3);
         do_instr(k, enc(k), fw, mw, rb(), ($urandom_range(0, 99) < 3));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
